// File: rtl/whac_round_timer_if.sv
// Signal bundle between the game logic and the round timer.
// The master side drives the game controls; the slave side is the timer.
interface whac_round_timer_if;
  logic       start;
  logic       pause;
  logic       hit;
  logic [7:0] target;
  logic       running;
  logic [6:0] secs_left;
  logic [3:0] secs_tens;
  logic [3:0] secs_ones;
  logic [7:0] score;
  logic       timeUp;
  logic       W;
  logic       enable;

  modport master (
    output start, pause, hit, target,
    input  running, secs_left, secs_tens, secs_ones, score, timeUp, W, enable
  );

  modport slave (
    input  start, pause, hit, target,
    output running, secs_left, secs_tens, secs_ones, score, timeUp, W, enable
  );
endinterface

// File: rtl/whac_round_timer.sv
// Round controller for whac-a-go: per-round countdown, hit scoring against a
// target latched at start, and the timeUp / W / enable outputs that drive the
// sound-effect player. Remaining seconds are exported in binary and BCD.
//
//   state   | meaning
//   IDLE    | after reset, waiting for the first start; audio disabled
//   RUN     | counting down, hits are scored
//   PAUSE   | countdown frozen, prescaler held, hits ignored
//   EXPIRED | timeUp held high for TIMEUP_HOLD cycles
//   DONE    | round over, score / W / secs_left=0 held until next start
module whac_round_timer #(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int ROUND_SECONDS   = 30,
  parameter int TIMEUP_HOLD     = 50000000
) (
  input logic               CLOCK_50,
  input logic               reset,
  whac_round_timer_if.slave bus
);

  localparam int PW = (CLOCK_FREQUENCY > 1) ? $clog2(CLOCK_FREQUENCY) : 1;
  localparam int HW = (TIMEUP_HOLD > 1) ? $clog2(TIMEUP_HOLD) : 1;
  localparam logic [PW-1:0] PRESC_RELOAD = PW'(CLOCK_FREQUENCY - 1);
  localparam logic [HW-1:0] HOLD_RELOAD  = HW'(TIMEUP_HOLD - 1);
  localparam logic [6:0]    SECS_INIT    = 7'(ROUND_SECONDS);

  typedef enum logic [2:0] {IDLE, RUN, PAUSE, EXPIRED, DONE} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [HW-1:0] hold;
  logic [7:0]    target_q;
  logic [6:0]    secs_q;
  logic [7:0]    score_q;
  logic          running_q;
  logic          time_up_q;
  logic          w_q;
  logic          enable_q;

  logic          counting;
  logic          tick;
  logic [7:0]    score_next;

  // Countdown advances in RUN, and also on the cycle PAUSE releases, so a
  // pause of N cycles delays expiry by exactly N cycles.
  always_comb begin
    counting   = ((state == RUN) || (state == PAUSE)) && !bus.pause;
    tick       = counting && (presc == '0);
    score_next = score_q;
    if ((state == RUN) && bus.hit && (score_q != 8'hFF))
      score_next = score_q + 8'd1;
  end

  // Round FSM with all outputs registered.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      presc     <= PRESC_RELOAD;
      hold      <= '0;
      target_q  <= '0;
      secs_q    <= SECS_INIT;
      score_q   <= '0;
      running_q <= 1'b0;
      time_up_q <= 1'b0;
      w_q       <= 1'b0;
      enable_q  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state     <= RUN;
            presc     <= PRESC_RELOAD;
            target_q  <= bus.target;
            secs_q    <= SECS_INIT;
            score_q   <= '0;
            w_q       <= 1'b0;
            running_q <= 1'b1;
            time_up_q <= 1'b0;
            enable_q  <= 1'b1;
          end
        end
        RUN, PAUSE: begin
          score_q <= score_next;
          if (bus.pause) begin
            state <= PAUSE;
          end else begin
            state <= RUN;
            if (tick) begin
              presc  <= PRESC_RELOAD;
              secs_q <= secs_q - 7'd1;
              // W includes a hit landing on the expiry cycle itself.
              if (secs_q == 7'd1) begin
                state     <= EXPIRED;
                running_q <= 1'b0;
                time_up_q <= 1'b1;
                hold      <= HOLD_RELOAD;
                w_q       <= (score_next >= target_q);
              end
            end else begin
              presc <= presc - 1'b1;
            end
          end
        end
        EXPIRED: begin
          if (hold == '0) begin
            state     <= DONE;
            time_up_q <= 1'b0;
          end else begin
            hold <= hold - 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          running_q <= 1'b0;
          time_up_q <= 1'b0;
          enable_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.running   = running_q;
  assign bus.secs_left = secs_q;
  assign bus.secs_tens = 4'(secs_q / 7'd10);
  assign bus.secs_ones = 4'(secs_q % 7'd10);
  assign bus.score     = score_q;
  assign bus.timeUp    = time_up_q;
  assign bus.W         = w_q;
  assign bus.enable    = enable_q;

endmodule

// File: tb/tb_whac_round_timer.sv
// Bench for whac_round_timer: a 3-second instance for most scenarios and a
// 99-second instance for score saturation. Expected round results go into a
// queue at start and are popped when timeUp rises.
module tb_whac_round_timer;
  localparam int CF = 10;
  localparam int RS = 3;
  localparam int TH = 20;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;
  always #5 CLOCK_50 = ~CLOCK_50;

  whac_round_timer_if bus();
  whac_round_timer_if bus99();

  whac_round_timer #(.CLOCK_FREQUENCY(CF), .ROUND_SECONDS(RS), .TIMEUP_HOLD(TH))
    dut (.CLOCK_50(CLOCK_50), .reset(reset), .bus(bus));
  whac_round_timer #(.CLOCK_FREQUENCY(CF), .ROUND_SECONDS(99), .TIMEUP_HOLD(TH))
    dut99 (.CLOCK_50(CLOCK_50), .reset(reset), .bus(bus99));

  typedef struct {
    logic [7:0] score;
    logic       w;
    int         cycles;
  } round_t;

  round_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  function automatic logic f_tu(bit big);  return big ? bus99.timeUp  : bus.timeUp;  endfunction
  function automatic logic f_run(bit big); return big ? bus99.running : bus.running; endfunction
  function automatic logic f_w(bit big);   return big ? bus99.W       : bus.W;       endfunction
  function automatic logic f_en(bit big);  return big ? bus99.enable  : bus.enable;  endfunction
  function automatic logic [7:0] f_score(bit big); return big ? bus99.score : bus.score; endfunction
  function automatic logic [6:0] f_secs(bit big);  return big ? bus99.secs_left : bus.secs_left; endfunction

  task automatic cycle();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Start a round; cycles=0 means the round will be aborted and has no result.
  task automatic do_start(bit big, logic [7:0] tgt, int n_hits, int cycles);
    round_t r;
    r.score  = (n_hits > 255) ? 8'd255 : 8'(n_hits);
    r.w      = (r.score >= tgt);
    r.cycles = cycles;
    if (cycles > 0) exp_q.push_back(r);
    if (big) begin bus99.target = tgt; bus99.start = 1'b1; end
    else     begin bus.target   = tgt; bus.start   = 1'b1; end
    cycle();
    bus.start = 1'b0;
    bus99.start = 1'b0;
    t0 = cyc;
    checks++; if (f_run(big) !== 1'b1) begin errors++; $display("FAIL start_running got %b exp 1", f_run(big)); end
    checks++; if (f_score(big) !== 8'd0) begin errors++; $display("FAIL start_score got %0d exp 0", f_score(big)); end
    checks++; if (f_w(big) !== 1'b0) begin errors++; $display("FAIL start_w got %b exp 0", f_w(big)); end
    checks++; if (f_secs(big) !== (big ? 7'd99 : 7'd3)) begin errors++; $display("FAIL start_secs got %0d", f_secs(big)); end
  endtask

  task automatic check_expiry(bit big, bit poke_start);
    round_t r;
    int n;
    while (!f_tu(big) && (cyc - t0) < 1100) cycle();
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL scoreboard_empty got timeUp with no expected round");
      return;
    end
    r = exp_q.pop_front();
    if ((cyc - t0) !== r.cycles) begin errors++; $display("FAIL expiry_time got %0d exp %0d", cyc - t0, r.cycles); end
    checks++; if (f_score(big) !== r.score) begin errors++; $display("FAIL expiry_score got %0d exp %0d", f_score(big), r.score); end
    checks++; if (f_w(big) !== r.w) begin errors++; $display("FAIL expiry_w got %b exp %b", f_w(big), r.w); end
    checks++; if (f_secs(big) !== 7'd0) begin errors++; $display("FAIL expiry_secs got %0d exp 0", f_secs(big)); end
    checks++; if (f_run(big) !== 1'b0) begin errors++; $display("FAIL expiry_running got %b exp 0", f_run(big)); end
    n = 0;
    while (f_tu(big) && n < 100) begin
      if (poke_start && n == 5) begin
        if (big) bus99.start = 1'b1; else bus.start = 1'b1;
      end
      cycle();
      bus.start = 1'b0;
      bus99.start = 1'b0;
      n++;
    end
    checks++; if (n !== TH) begin errors++; $display("FAIL timeup_width got %0d exp %0d", n, TH); end
    checks++; if (f_en(big) !== 1'b1) begin errors++; $display("FAIL done_enable got %b exp 1", f_en(big)); end
    checks++; if (f_score(big) !== r.score) begin errors++; $display("FAIL done_score got %0d exp %0d", f_score(big), r.score); end
    checks++; if (f_w(big) !== r.w) begin errors++; $display("FAIL done_w got %b exp %b", f_w(big), r.w); end
    checks++; if (f_run(big) !== 1'b0) begin errors++; $display("FAIL done_running got %b exp 0", f_run(big)); end
  endtask

  task automatic check_reset_values(string tag);
    checks++; if (bus.secs_left !== 7'd3) begin errors++; $display("FAIL %s_secs got %0d exp 3", tag, bus.secs_left); end
    checks++; if (bus.secs_tens !== 4'd0 || bus.secs_ones !== 4'd3) begin errors++; $display("FAIL %s_bcd got %0d%0d exp 03", tag, bus.secs_tens, bus.secs_ones); end
    checks++; if (bus.score !== 8'd0) begin errors++; $display("FAIL %s_score got %0d exp 0", tag, bus.score); end
    checks++; if (bus.timeUp !== 1'b0) begin errors++; $display("FAIL %s_timeup got %b exp 0", tag, bus.timeUp); end
    checks++; if (bus.W !== 1'b0) begin errors++; $display("FAIL %s_w got %b exp 0", tag, bus.W); end
    checks++; if (bus.enable !== 1'b0) begin errors++; $display("FAIL %s_enable got %b exp 0", tag, bus.enable); end
    checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL %s_running got %b exp 0", tag, bus.running); end
  endtask

  task automatic test_reset();
    cycle(); cycle();
    check_reset_values("in_reset");
    reset = 1'b0;
    cycle();
    bus.hit = 1'b1; bus99.hit = 1'b1;
    cycle();
    bus.hit = 1'b0; bus99.hit = 1'b0;
    cycle();
    check_reset_values("idle");
    checks++; if (bus99.secs_tens !== 4'd9 || bus99.secs_ones !== 4'd9) begin errors++; $display("FAIL bcd99 got %0d%0d exp 99", bus99.secs_tens, bus99.secs_ones); end
  endtask

  task automatic test_basic_round();
    do_start(0, 8'd0, 0, 30);
    for (int k = 1; k <= 29; k++) begin
      cycle();
      if (k == 9)  begin checks++; if (bus.secs_left !== 7'd3) begin errors++; $display("FAIL basic_secs9 got %0d exp 3", bus.secs_left); end end
      if (k == 10) begin checks++; if (bus.secs_left !== 7'd2 || bus.secs_ones !== 4'd2) begin errors++; $display("FAIL basic_secs10 got %0d exp 2", bus.secs_left); end end
      if (k == 20) begin checks++; if (bus.secs_left !== 7'd1) begin errors++; $display("FAIL basic_secs20 got %0d exp 1", bus.secs_left); end end
      if (k == 29) begin checks++; if (bus.timeUp !== 1'b0) begin errors++; $display("FAIL basic_early_timeup got %b exp 0", bus.timeUp); end end
    end
    check_expiry(0, 0);
  endtask

  task automatic test_hits_target();
    do_start(0, 8'd2, 1, 30);
    for (int k = 1; k <= 30; k++) begin
      bus.hit = (k == 5);
      cycle();
      bus.hit = 1'b0;
    end
    check_expiry(0, 0);
    do_start(0, 8'd2, 2, 30);
    for (int k = 1; k <= 30; k++) begin
      bus.hit = (k == 5) || (k == 30);
      cycle();
      bus.hit = 1'b0;
    end
    check_expiry(0, 0);
  endtask

  task automatic test_pause();
    do_start(0, 8'd0, 1, 45);
    for (int k = 1; k <= 45; k++) begin
      bus.pause = (k >= 12 && k <= 26);
      bus.hit   = (k == 5) || (k == 15) || (k == 20);
      cycle();
      bus.hit = 1'b0;
      if (k == 20) begin
        checks++; if (bus.score !== 8'd1) begin errors++; $display("FAIL pause_score got %0d exp 1", bus.score); end
        checks++; if (bus.running !== 1'b1) begin errors++; $display("FAIL pause_running got %b exp 1", bus.running); end
      end
      if (k == 26) begin checks++; if (bus.secs_left !== 7'd2) begin errors++; $display("FAIL pause_secs got %0d exp 2", bus.secs_left); end end
      if (k == 44) begin checks++; if (bus.timeUp !== 1'b0) begin errors++; $display("FAIL pause_early_timeup got %b exp 0", bus.timeUp); end end
    end
    bus.pause = 1'b0;
    check_expiry(0, 0);
  endtask

  task automatic test_saturation();
    do_start(1, 8'd255, 300, 990);
    for (int k = 1; k <= 990; k++) begin
      bus99.hit   = (k <= 600) && (k % 2 == 1);
      bus99.start = (k == 100);
      cycle();
      bus99.hit = 1'b0;
      bus99.start = 1'b0;
      if (k == 200) begin checks++; if (bus99.secs_left !== 7'd79) begin errors++; $display("FAIL sat_no_restart got %0d exp 79", bus99.secs_left); end end
      if (k == 600) begin checks++; if (bus99.score !== 8'd255) begin errors++; $display("FAIL sat_score got %0d exp 255", bus99.score); end end
    end
    check_expiry(1, 1);
  endtask

  task automatic test_mid_reset();
    do_start(0, 8'd3, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      bus.hit = (k <= 5);
      cycle();
      bus.hit = 1'b0;
    end
    checks++; if (bus.score !== 8'd5) begin errors++; $display("FAIL midrun_score got %0d exp 5", bus.score); end
    reset = 1'b1;
    #1;
    check_reset_values("reset_run");
    cycle(); cycle();
    reset = 1'b0;
    do_start(0, 8'd0, 0, 0);
    for (int k = 1; k <= 30; k++) cycle();
    checks++; if (bus.timeUp !== 1'b1) begin errors++; $display("FAIL pre_reset_timeup got %b exp 1", bus.timeUp); end
    reset = 1'b1;
    #1;
    check_reset_values("reset_expired");
    cycle(); cycle();
    reset = 1'b0;
    cycle();
    do_start(0, 8'd0, 0, 30);
    for (int k = 1; k <= 30; k++) cycle();
    check_expiry(0, 0);
  endtask

  initial begin
    bus.start = 1'b0; bus.pause = 1'b0; bus.hit = 1'b0; bus.target = 8'd0;
    bus99.start = 1'b0; bus99.pause = 1'b0; bus99.hit = 1'b0; bus99.target = 8'd0;
    test_reset();
    test_basic_round();
    test_hits_target();
    test_pause();
    test_saturation();
    test_mid_reset();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
